// File: rtl/toggle_meter_pkg.sv
// Shared types for the toggle rate meter: FSM states and the speed code.
package toggle_meter_pkg;

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_IDLE = 2'd1,
        ST_DIV  = 2'd2,
        ST_HOLD = 2'd3
    } meter_state_t;

    localparam int SPEED_MAX = 15;

    typedef logic [3:0] speed_t;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, W cycles per divide.
module seq_divider #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient
);

    localparam int STEP_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(W - 1);

    logic [W-1:0]      rem_q;
    logic [W-1:0]      dq_q;
    logic [W-1:0]      div_q;
    logic [STEP_W-1:0] step_q;
    logic              busy_q;

    logic [W:0]   trial;
    logic         fits;
    logic [W-1:0] diff;
    logic [W-1:0] rem_next;
    logic [W-1:0] dq_next;

    // A zero divisor always "fits", so the quotient naturally comes out all ones.
    always_comb begin
        trial    = {rem_q, dq_q[W-1]};
        fits     = (trial >= {1'b0, div_q});
        diff     = trial[W-1:0] - div_q;
        rem_next = fits ? diff : trial[W-1:0];
        dq_next  = {dq_q[W-2:0], fits};
    end

    assign busy     = busy_q;
    assign done     = busy_q && (step_q == LAST_STEP);
    assign quotient = dq_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            dq_q   <= '0;
            div_q  <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            rem_q  <= '0;
            dq_q   <= dividend;
            div_q  <= divisor;
            step_q <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q  <= rem_next;
            dq_q   <= dq_next;
            step_q <= step_q + 1'b1;
            if (done)
                busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/toggle_rate_meter.sv
// Measures edge-to-edge half-period of toggle_in and reports the matching speed code.
//   state | meaning
//   ARM   | waiting for a first edge to start timing, no result pending
//   IDLE  | timing an interval, next edge starts a divide
//   DIV   | divider running on the captured interval
//   HOLD  | result presented on meas_valid until accepted
module toggle_rate_meter
    import toggle_meter_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             toggle_in,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [3:0]       speed_out,
    output logic [CNT_W-1:0] half_period,
    output logic             timeout,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_FREQ + 1);
    localparam logic [CNT_W-1:0] DIVIDEND = CNT_W'(CLK_FREQ);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   tog_edge;
    logic [CNT_W-1:0]       cnt_q;
    meter_state_t           state_q;

    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic [CNT_W-1:0] div_quot;
    speed_t           speed_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], toggle_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tog_edge = sync_q[SYNC_STAGES-1] ^ hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (tog_edge)
            cnt_q <= '0;
        else if (cnt_q != CNT_MAX)
            cnt_q <= cnt_q + 1'b1;
    end

    // cnt at the edge is P-1, which is exactly the divisor D.
    assign div_start = (state_q == ST_IDLE) && tog_edge;
    assign speed_sat = (div_quot > CNT_W'(SPEED_MAX)) ? speed_t'(SPEED_MAX) : div_quot[3:0];

    seq_divider #(
        .W (CNT_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (DIVIDEND),
        .divisor  (cnt_q),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ARM;
            meas_valid  <= 1'b0;
            speed_out   <= '0;
            half_period <= '0;
            timeout     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            unique case (state_q)
                ST_ARM: begin
                    if (tog_edge)
                        state_q <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (tog_edge) begin
                        half_period <= cnt_q + 1'b1;
                        timeout     <= 1'b0;
                        state_q     <= ST_DIV;
                    end else if (cnt_q == CNT_MAX) begin
                        speed_out   <= '0;
                        timeout     <= 1'b1;
                        half_period <= cnt_q;
                        meas_valid  <= 1'b1;
                        state_q     <= ST_HOLD;
                    end
                end
                ST_DIV: begin
                    if (tog_edge)
                        overrun <= 1'b1;
                    if (div_done) begin
                        speed_out  <= speed_sat;
                        meas_valid <= 1'b1;
                        state_q    <= ST_HOLD;
                    end else if (!div_busy) begin
                        // divider lost without finishing: drop the sample and keep timing
                        state_q <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (tog_edge)
                        overrun <= 1'b1;
                    if (meas_valid && meas_ready) begin
                        meas_valid <= 1'b0;
                        state_q    <= timeout ? ST_ARM : ST_IDLE;
                    end
                end
                default: state_q <= ST_ARM;
            endcase
        end
    end

endmodule

// File: tb/tb_toggle_rate_meter.sv
// Scoreboard bench for toggle_rate_meter at CLK_FREQ=1000, CNT_W=16.
module tb_toggle_rate_meter;

    localparam int CLK_FREQ    = 1000;
    localparam int CNT_W       = 16;
    localparam int SYNC_STAGES = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             toggle_in;
    logic             meas_valid;
    logic             meas_ready;
    logic [3:0]       speed_out;
    logic [CNT_W-1:0] half_period;
    logic             timeout;
    logic             overrun;

    typedef struct {
        logic [3:0]       spd;
        logic [CNT_W-1:0] hp;
        logic             to;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_tog = 0;

    toggle_rate_meter #(
        .CLK_FREQ    (CLK_FREQ),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .toggle_in   (toggle_in),
        .meas_valid  (meas_valid),
        .meas_ready  (meas_ready),
        .speed_out   (speed_out),
        .half_period (half_period),
        .timeout     (timeout),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int spd, input int hp, input logic to);
        exp_t e;
        e.spd = 4'(spd);
        e.hp  = CNT_W'(hp);
        e.to  = to;
        sb_q.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // toggles exactly `interval` clock cycles after the previous toggle
    task automatic toggle_at(input int interval);
        forever begin
            @(posedge clk);
            #1;
            if (cyc - last_tog >= interval) break;
        end
        toggle_in = ~toggle_in;
        last_tog  = cyc;
    endtask

    task automatic drain(input string tag, input int max_cycles);
        int c = 0;
        while (sb_q.size() != 0 && c < max_cycles) begin
            @(posedge clk);
            #1;
            c++;
        end
        check_val(tag, sb_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && meas_valid && meas_ready) begin
            if (sb_q.size() == 0) begin
                check_val("result_expected", sb_q.size(), 1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_val("speed_out", speed_out, e.spd);
                check_val("half_period", half_period, e.hp);
                check_val("timeout", timeout, e.to);
            end
        end
    end

    initial begin
        int k;
        rst_n      = 1'b0;
        toggle_in  = 1'b0;
        meas_ready = 1'b1;
        wait_cycles(3);
        check_val("rst_meas_valid", meas_valid, 0);
        check_val("rst_speed_out", speed_out, 0);
        check_val("rst_half_period", half_period, 0);
        check_val("rst_timeout", timeout, 0);
        check_val("rst_overrun", overrun, 0);
        rst_n = 1'b1;

        // steady 251-cycle toggling: first edge only arms
        toggle_at(1);
        for (int i = 0; i < 4; i++) begin
            toggle_at(251);
            push_exp(4, 251, 1'b0);
        end

        // speed sweep, including the s=1 interval right below the timeout threshold
        for (int s = 1; s <= 15; s++) begin
            toggle_at(CLK_FREQ / s + 1);
            push_exp(s, CLK_FREQ / s + 1, 1'b0);
        end
        drain("drain_sweep", 100);
        check_val("overrun_after_sweep", overrun, 0);

        // timeout after the last sweep edge, then re-arm needs a fresh edge
        push_exp(0, CLK_FREQ + 1, 1'b1);
        drain("drain_timeout", 1200);
        toggle_at(1);
        toggle_at(251);
        push_exp(4, 251, 1'b0);
        wait_cycles(30);
        check_val("overrun_before_stall", overrun, 0);

        // consumer stall: result held stable, edges dropped as overrun
        meas_ready = 1'b0;
        toggle_at(251);
        push_exp(4, 251, 1'b0);
        wait_cycles(40);
        check_val("stall_valid_early", meas_valid, 1);
        check_val("stall_speed_early", speed_out, 4);
        check_val("stall_hp_early", half_period, 251);
        toggle_at(251);
        toggle_at(251);
        wait_cycles(100);
        check_val("stall_valid_late", meas_valid, 1);
        check_val("stall_speed_late", speed_out, 4);
        check_val("stall_hp_late", half_period, 251);
        check_val("stall_overrun", overrun, 1);
        meas_ready = 1'b1;
        toggle_at(251);
        push_exp(4, 251, 1'b0);
        drain("drain_stall", 60);

        // fast toggling inside the divider window
        rst_n     = 1'b0;
        toggle_in = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        check_val("overrun_after_reset", overrun, 0);
        toggle_at(1);
        toggle_at(10);
        push_exp(15, 10, 1'b0);
        toggle_at(10);
        wait_cycles(40);
        drain("drain_fast", 20);
        check_val("fast_overrun", overrun, 1);

        // reset while the divider is running
        toggle_at(251);
        wait_cycles(8);
        rst_n = 1'b0;
        #1;
        check_val("middiv_meas_valid", meas_valid, 0);
        check_val("middiv_speed_out", speed_out, 0);
        check_val("middiv_half_period", half_period, 0);
        check_val("middiv_timeout", timeout, 0);
        check_val("middiv_overrun", overrun, 0);
        toggle_in = 1'b0;
        wait_cycles(3);
        rst_n = 1'b1;
        toggle_at(1);
        toggle_at(251);
        push_exp(4, 251, 1'b0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!meas_valid && k < 100);
        check_val("meas_latency", k, SYNC_STAGES + CNT_W + 2);
        drain("drain_final", 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/toggle_rate_meter.md
# toggle_rate_meter

Measures the half-period of an incoming LED toggle waveform and reports the equivalent 4-bit speed code, i.e. the value that produced the waveform on the toggle generator's `speed` input. It is the receive/measure end of the toggle link: used on the bench and in loopback self-test to close the loop on the toggle generator. It samples an asynchronous toggle, times edge-to-edge intervals, divides the clock frequency by each interval with a sequential divider, and presents each result on a valid/ready handshake.

## Interface
- `CLK_FREQ`, default 50_000_000: clock frequency in Hz; the dividend for every speed computation.
- `CNT_W`, default 32: width of the interval counter and of the `half_period` output.
- `SYNC_STAGES`, default 2: synchronizer depth on `toggle_in`; minimum 2.
- Reset `rst_n` is asynchronous and active-low; the clock is `clk`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `toggle_in`  in  1  asynchronous toggle waveform under measurement.
- `meas_valid`  out  1  result available; held until accepted.
- `meas_ready`  in  1  consumer accepts result when high with `meas_valid`.
- `speed_out`  out  4  measured speed code, 0..15.
- `half_period`  out  CNT_W  cycles between the two edges measured.
- `timeout`  out  1  result is a timeout report, not a measurement.
- `overrun`  out  1  sticky; at least one edge was dropped because the block was busy.

## Operation
- `toggle_in` passes through `SYNC_STAGES` flops, then one history flop. Any transition, rising or falling, is an edge.
- Interval counter `cnt`:
  - Clears to 0 in each edge cycle.
  - Otherwise increments, saturating at `CLK_FREQ+1`.
  - Captured interval is P = `cnt`+1, the cycles between consecutive edge cycles.
- FSM states: ARM, IDLE, DIV, HOLD. Reset enters ARM.
- ARM:
  - The first edge only starts timing; no result is produced. Go to IDLE.
- IDLE:
  - On an edge, latch P into `half_period`, start the divider with D = P-1, and go to DIV.
  - If `cnt` reaches `CLK_FREQ+1`, set `speed_out`=0, `timeout`=1, `half_period`=`cnt`, and go to HOLD.
- DIV:
  - One quotient bit is computed per cycle, CNT_W cycles total. Then load `speed_out` and go to HOLD.
- HOLD:
  - `meas_valid`=1 and outputs stay stable.
  - On `meas_valid && meas_ready`, leave HOLD:
    - after a timeout result, go to ARM, because the next interval is partial;
    - otherwise go to IDLE.
- Arithmetic:
  - Quotient Q = floor(`CLK_FREQ`/D), unsigned.
  - If D=0 or Q>15, `speed_out`=15.
  - For a source speed s in 1..15: D = `CLK_FREQ`/s and Q = s exactly.
- Edges during DIV or HOLD:
  - The edge still clears `cnt`, so timing restarts.
  - The sample is discarded and `overrun` is set. `overrun` clears only on reset.
- Simultaneous edge and timeout threshold in IDLE: the edge wins and a measurement is started.
- Simultaneous handshake and edge in HOLD: the handshake completes, the edge is dropped and counts as an overrun, and the FSM goes to IDLE or ARM as normal.
- Reset mid-operation (any state) returns to ARM and clears all registers. The divider aborts.

## Timing
- Reset values:
  - `meas_valid`=0, `speed_out`=0, `half_period`=0, `timeout`=0, `overrun`=0.
  - `cnt`=0; synchronizer and history flops=0.
- Edge detection: the edge cycle is `SYNC_STAGES`+1 cycles after `toggle_in` changes.
- Measurement latency: if the edge cycle is E, `meas_valid` rises in cycle E+CNT_W+1 (E+33 at default).
- Timeout latency: `meas_valid` rises the cycle after `cnt` hits `CLK_FREQ+1`.
- Handshake rules:
  - `meas_valid` never depends combinationally on `meas_ready`.
  - `meas_valid` drops the cycle after acceptance.
  - No back-to-back results are possible, since the minimum gap between results is CNT_W+2 cycles.
- Minimum measurable interval without overrun: P > CNT_W+2 cycles plus the handshake wait.

## Structure
- Package `toggle_meter_pkg` holds:
  - the FSM state enum (ARM, IDLE, DIV, HOLD);
  - the `SPEED_MAX`=15 constant;
  - the speed-code type (logic [3:0]).
- Sub-module `seq_divider`:
  - unsigned restoring divider, parameter W;
  - ports: start, dividend, divisor, busy, done, quotient;
  - divide-by-zero sets quotient to all ones.
  - `toggle_rate_meter` instantiates it with W=CNT_W.

## Test plan
All scenarios run with `CLK_FREQ`=1000 and `CNT_W`=16 unless stated.
- Toggle every 251 cycles, `meas_ready`=1 → first edge is discarded; each later result has `speed_out`=4, `half_period`=251, `timeout`=0.
- Sweep s=1..15 with interval `CLK_FREQ`/s+1 → `speed_out`=s every time; `overrun` stays 0.
- Toggle every 10 cycles, i.e. inside the divider window → `speed_out`=15 and `overrun`=1 after the second interval.
- No edges for 1002 cycles after arming → `meas_valid` with `speed_out`=0, `timeout`=1, `half_period`=1001; the FSM returns to ARM after the handshake.
- Hold `meas_ready`=0 for 500 cycles during steady toggling → `meas_valid`, `speed_out` and `half_period` stay stable; dropped edges set `overrun`.
- Assert `rst_n` low mid-DIV → all outputs return to reset values immediately; the next result requires two fresh edges.
